// File: rtl/core_mc_seq_pkg.sv
// Shared definitions for the multi-cycle fetch/execute sequencer.
package core_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5,
        S_FAULT = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_IMEM_TO  = 2'd1,
        FC_DMEM_TO  = 2'd2,
        FC_MISALIGN = 2'd3
    } fault_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/core_mc_seq_mem_wait_timer.sv
// Memory wait counter shared by the fetch and data-access phases.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic active_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry fires in the cycle the count would reach TIMEOUT; a same-cycle ack wins.
    assign expire_o = (TIMEOUT != 0) && active_i && !ack_i && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (!active_i || ack_i) begin
            cnt_d = '0;
        end else if (!expire_o && (TIMEOUT != 0)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/core_mc_seq.sv
// Multi-cycle sequencer owning PC, IR, MDR and counters around a combinational decoder/ALU.
module core_mc_seq
    import core_pkg::*;
#(
    parameter int unsigned        DWIDTH    = 32,
    parameter logic [DWIDTH-1:0]  RESET_PC  = '0,
    parameter int unsigned        TIMEOUT   = 16,
    parameter int unsigned        CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 step_mode,
    input  logic                 stop,
    output logic                 imem_req,
    output logic [DWIDTH-1:0]    imem_addr,
    input  logic                 imem_ack,
    input  logic [DWIDTH-1:0]    imem_rdata,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    input  logic [DWIDTH-1:0]    dmem_rdata,
    input  logic                 dec_mem,
    input  logic                 dec_store,
    input  logic                 dec_regwen,
    input  logic                 dec_halt,
    input  logic                 pc_sel,
    input  logic [DWIDTH-1:0]    alu_result,
    output logic [DWIDTH-1:0]    pc,
    output logic [DWIDTH-1:0]    pc_plus4,
    output logic [DWIDTH-1:0]    ir,
    output logic [DWIDTH-1:0]    mdr,
    output logic                 reg_we,
    output logic [2:0]           state_o,
    output logic                 halted,
    output logic                 fault,
    output logic [1:0]           fault_cause,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instret_cnt
);

    state_e                state_q;
    logic [DWIDTH-1:0]     pc_q, ir_q, mdr_q;
    logic [CNT_WIDTH-1:0]  cycle_q, instret_q;
    fault_e                cause_q;
    logic                  imem_req_q, dmem_req_q, halted_q, fault_q;
    logic                  wait_active, wait_ack, wait_expire;
    logic                  misalign;
    logic                  busy;

    assign wait_active = (state_q == S_FETCH) || (state_q == S_MEM);
    assign wait_ack    = (state_q == S_FETCH) ? imem_ack : dmem_ack;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .active_i (wait_active),
        .ack_i    (wait_ack),
        .expire_o (wait_expire)
    );

    assign misalign = pc_sel && alu_result[1];
    assign busy     = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                      (state_q == S_MEM)   || (state_q == S_WB);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= DWIDTH'(NOP_INSN);
            mdr_q      <= '0;
            cycle_q    <= '0;
            instret_q  <= '0;
            cause_q    <= FC_NONE;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            if (busy) begin
                cycle_q <= cycle_q + CNT_WIDTH'(1);
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_q       <= imem_rdata;
                        state_q    <= S_EXEC;
                        imem_req_q <= 1'b0;
                    end else if (wait_expire) begin
                        cause_q    <= FC_IMEM_TO;
                        fault_q    <= 1'b1;
                        state_q    <= S_FAULT;
                        imem_req_q <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (dec_halt) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else if (dec_mem) begin
                        dmem_req_q <= 1'b1;
                        state_q    <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (!dec_store) begin
                            mdr_q <= dmem_rdata;
                        end
                        dmem_req_q <= 1'b0;
                        state_q    <= S_WB;
                    end else if (wait_expire) begin
                        cause_q    <= FC_DMEM_TO;
                        fault_q    <= 1'b1;
                        dmem_req_q <= 1'b0;
                        state_q    <= S_FAULT;
                    end
                end
                S_WB: begin
                    // A misaligned target leaves pc on the offending instruction.
                    if (misalign) begin
                        cause_q <= FC_MISALIGN;
                        fault_q <= 1'b1;
                        state_q <= S_FAULT;
                    end else begin
                        pc_q      <= pc_sel ? {alu_result[DWIDTH-1:1], 1'b0} : pc_plus4;
                        instret_q <= instret_q + CNT_WIDTH'(1);
                        if (stop || step_mode) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q    <= S_FETCH;
                            imem_req_q <= 1'b1;
                        end
                    end
                end
                S_HALT, S_FAULT: begin
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_req_q && dec_store;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + DWIDTH'(4);
    assign ir          = ir_q;
    assign mdr         = mdr_q;
    assign reg_we      = (state_q == S_WB) && dec_regwen && !misalign;
    assign state_o     = state_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

// File: tb/tb_core_mc_seq.sv
// Directed self-checking bench for core_mc_seq (RESET_PC = 0x100, TIMEOUT = 4).
module tb_core_mc_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, step_mode, stop;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_rdata;
    logic        dec_mem, dec_store, dec_regwen, dec_halt, pc_sel;
    logic [31:0] alu_result;
    logic [31:0] pc, pc_plus4, ir, mdr;
    logic        reg_we, halted, fault;
    logic [2:0]  state_o;
    logic [1:0]  fault_cause;
    logic [31:0] cycle_cnt, instret_cnt;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [31:0] ST_IDLE = 0, ST_FETCH = 1, ST_EXEC = 2, ST_MEM = 3,
                            ST_WB = 4, ST_HALT = 5, ST_FAULT = 6;

    core_mc_seq #(
        .DWIDTH    (32),
        .RESET_PC  (32'h0000_0100),
        .TIMEOUT   (4),
        .CNT_WIDTH (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .step_mode   (step_mode),
        .stop        (stop),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .dec_mem     (dec_mem),
        .dec_store   (dec_store),
        .dec_regwen  (dec_regwen),
        .dec_halt    (dec_halt),
        .pc_sel      (pc_sel),
        .alu_result  (alu_result),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .ir          (ir),
        .mdr         (mdr),
        .reg_we      (reg_we),
        .state_o     (state_o),
        .halted      (halted),
        .fault       (fault),
        .fault_cause (fault_cause),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; step_mode = 0; stop = 0;
        imem_ack = 0; imem_rdata = '0; dmem_ack = 0; dmem_rdata = '0;
        dec_mem = 0; dec_store = 0; dec_regwen = 0; dec_halt = 0;
        pc_sel = 0; alu_result = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        reset = 0;
        do_reset();

        // reset state
        chk("rst_state", 32'(state_o), ST_IDLE);
        chk("rst_pc", pc, 32'h100);
        chk("rst_pc4", pc_plus4, 32'h104);
        chk("rst_ir", ir, 32'h13);
        chk("rst_mdr", mdr, 0);
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_instret", instret_cnt, 0);
        chk("rst_flags", {27'd0, imem_req, dmem_req, reg_we, halted, fault}, 0);
        chk("rst_cause", 32'(fault_cause), 0);

        // ADDI with zero-latency fetch
        imem_ack = 1; imem_rdata = 32'h0050_0093; dec_regwen = 1;
        chk("idle_no_start", 32'(state_o), ST_IDLE);
        start = 1; tick(); start = 0;
        chk("addi_fetch", 32'(state_o), ST_FETCH);
        chk("addi_ireq", 32'(imem_req), 1);
        chk("addi_iaddr", imem_addr, 32'h100);
        chk("addi_we_fetch", 32'(reg_we), 0);
        tick();
        chk("addi_exec", 32'(state_o), ST_EXEC);
        chk("addi_ir", ir, 32'h0050_0093);
        chk("addi_ireq_off", 32'(imem_req), 0);
        chk("addi_we_exec", 32'(reg_we), 0);
        imem_ack = 0;
        tick();
        chk("addi_wb", 32'(state_o), ST_WB);
        chk("addi_we_wb", 32'(reg_we), 1);
        tick();
        chk("addi_next_fetch", 32'(state_o), ST_FETCH);
        chk("addi_pc", pc, 32'h104);
        chk("addi_instret", instret_cnt, 1);
        chk("addi_cycle", cycle_cnt, 3);
        chk("addi_we_after", 32'(reg_we), 0);

        // load, dmem ack on the 4th MEM cycle
        imem_ack = 1; imem_rdata = 32'h0000_A103;
        dec_mem = 1; dec_store = 0; dec_regwen = 1; alu_result = 32'h300;
        tick();
        imem_ack = 0;
        chk("ld_exec", 32'(state_o), ST_EXEC);
        chk("ld_dreq_exec", 32'(dmem_req), 0);
        tick();
        chk("ld_mem1", 32'(state_o), ST_MEM);
        chk("ld_dreq1", 32'(dmem_req), 1);
        chk("ld_dwe", 32'(dmem_we), 0);
        chk("ld_we_mem", 32'(reg_we), 0);
        tick();
        chk("ld_dreq2", 32'(dmem_req), 1);
        tick();
        chk("ld_dreq3", 32'(dmem_req), 1);
        tick();
        chk("ld_dreq4", 32'(dmem_req), 1);
        chk("ld_mem4", 32'(state_o), ST_MEM);
        dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_ack = 0; dmem_rdata = '0;
        chk("ld_wb", 32'(state_o), ST_WB);
        chk("ld_mdr", mdr, 32'hDEAD_BEEF);
        chk("ld_dreq_wb", 32'(dmem_req), 0);
        chk("ld_we_wb", 32'(reg_we), 1);
        tick();
        dec_mem = 0;
        chk("ld_pc", pc, 32'h108);
        chk("ld_cycle", cycle_cnt, 10);
        chk("ld_instret", instret_cnt, 2);

        // JAL to 0x201 -> pc 0x200
        imem_ack = 1; imem_rdata = 32'h2000_00EF; pc_sel = 1; alu_result = 32'h201;
        tick(); imem_ack = 0;
        tick();
        chk("jal_wb_we", 32'(reg_we), 1);
        tick();
        chk("jal_pc", pc, 32'h200);
        chk("jal_instret", instret_cnt, 3);
        chk("jal_cycle", cycle_cnt, 13);

        // misaligned target 0x202
        imem_ack = 1; alu_result = 32'h202;
        tick(); imem_ack = 0;
        tick();
        chk("mis_wb", 32'(state_o), ST_WB);
        chk("mis_we_forced", 32'(reg_we), 0);
        tick();
        chk("mis_state", 32'(state_o), ST_FAULT);
        chk("mis_fault", 32'(fault), 1);
        chk("mis_cause", 32'(fault_cause), 3);
        chk("mis_pc", pc, 32'h200);
        chk("mis_instret", instret_cnt, 3);
        chk("mis_cycle", cycle_cnt, 16);
        start = 1; tick(); start = 0;
        chk("fault_sticky", 32'(state_o), ST_FAULT);
        chk("fault_cycle_hold", cycle_cnt, 16);
        chk("fault_ireq", 32'(imem_req), 0);

        // fetch timeout: no ack for 4 FETCH cycles
        do_reset();
        chk("to_rst_fault", 32'(fault), 0);
        start = 1; tick(); start = 0;
        tick(); tick(); tick();
        chk("to_fetch4", 32'(state_o), ST_FETCH);
        tick();
        chk("to_state", 32'(state_o), ST_FAULT);
        chk("to_cause", 32'(fault_cause), 1);
        chk("to_ireq", 32'(imem_req), 0);
        chk("to_pc", pc, 32'h100);
        chk("to_cycle", cycle_cnt, 4);

        // ack exactly on the 4th cycle wins
        do_reset();
        start = 1; tick(); start = 0;
        tick(); tick(); tick();
        imem_ack = 1; imem_rdata = 32'h13;
        tick(); imem_ack = 0;
        chk("to_ack4_exec", 32'(state_o), ST_EXEC);
        chk("to_ack4_nofault", 32'(fault), 0);

        // step mode over 3 instructions
        do_reset();
        step_mode = 1;
        for (int i = 0; i < 3; i++) begin
            start = 1; tick(); start = 0;
            imem_ack = 1; imem_rdata = 32'h13;
            tick(); imem_ack = 0;
            tick();
            tick();
            chk("step_idle", 32'(state_o), ST_IDLE);
        end
        chk("step_instret", instret_cnt, 3);
        chk("step_pc", pc, 32'h10C);
        step_mode = 0;

        // store with a stop pulse during MEM that must be lost
        start = 1; tick(); start = 0;
        imem_ack = 1; imem_rdata = 32'h0020_A023;
        dec_mem = 1; dec_store = 1; alu_result = 32'h400;
        tick(); imem_ack = 0;
        tick();
        chk("st_mem", 32'(state_o), ST_MEM);
        chk("st_dwe", 32'(dmem_we), 1);
        stop = 1; tick(); stop = 0;
        dmem_ack = 1; dmem_rdata = 32'h1234_5678;
        tick(); dmem_ack = 0;
        chk("st_wb", 32'(state_o), ST_WB);
        chk("st_mdr_keep", mdr, 0);
        tick();
        dec_mem = 0; dec_store = 0;
        chk("stop_lost", 32'(state_o), ST_FETCH);
        chk("st_instret", instret_cnt, 4);

        // stop held through WB
        imem_ack = 1; imem_rdata = 32'h13;
        tick(); imem_ack = 0;
        tick();
        stop = 1; tick(); stop = 0;
        chk("stop_idle", 32'(state_o), ST_IDLE);
        chk("stop_instret", instret_cnt, 5);
        chk("stop_pc", pc, 32'h114);

        // halt
        start = 1; tick(); start = 0;
        imem_ack = 1; imem_rdata = 32'h0000_0073; dec_halt = 1;
        tick(); imem_ack = 0;
        tick();
        chk("halt_state", 32'(state_o), ST_HALT);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_pc", pc, 32'h114);
        start = 1; tick(); start = 0;
        chk("halt_sticky", 32'(state_o), ST_HALT);
        dec_halt = 0;

        // async reset mid-MEM
        do_reset();
        start = 1; tick(); start = 0;
        imem_ack = 1; imem_rdata = 32'h0000_A103; dec_mem = 1;
        tick(); imem_ack = 0;
        tick();
        chk("ar_dreq_before", 32'(dmem_req), 1);
        #2 reset = 1;
        #1;
        chk("ar_dreq", 32'(dmem_req), 0);
        chk("ar_state", 32'(state_o), ST_IDLE);
        chk("ar_cycle", cycle_cnt, 0);
        chk("ar_instret", instret_cnt, 0);
        tick();
        reset = 0;
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
